trdb_branch_map: RTL and testbench
==================================

// Module: trdb_branch_map
// PURPOSE
//  Accumulates taken/not-taken outcomes of retired, qualified conditional branches into a branch map.
//  Sits directly upstream of the packet-format selection stage.
//  Supplies that stage with branch_map_empty/full, the pending branch count (pbc) and the map bits.
//  Cleared when the packet emitter reports that a packet carrying the map has been sent.
// PARAMETERS
//  MAP_LEN  31  max branches held; map width. Count width CW = $clog2(MAP_LEN+1) (5 at default)
// PORTS
//  clk_i         in   1       clock, all state updates on rising edge
//  rst_i         in   1       synchronous reset, active-high
//  valid_i       in   1       this-cycle instruction info valid
//  qualified_i   in   1       instruction passes trace filter
//  is_branch_i   in   1       retired instr is a conditional branch
//  branch_taken_i in  1       branch outcome, 1 = taken
//  flush_i       in   1       packet with branch map emitted this cycle; consume map
//  map_o         out  MAP_LEN branch map; bit i = i-th oldest unreported branch; 1 = NOT taken, 0 = taken
//  branches_o    out  CW      number of valid bits in map_o (pbc)
//  is_empty_o    out  1       branches_o == 0
//  is_full_o     out  1       branches_o == MAP_LEN
//  overflow_o    out  1       sticky: branch arrived while full and no flush
// BEHAVIOUR
//  Write condition: wr = valid_i & qualified_i & is_branch_i.
//  - When valid_i = 0 or qualified_i = 0: no state change regardless of the other inputs.
//  Reset (rst_i=1 at edge): map_o=0, branches_o=0, is_empty_o=1, is_full_o=0, overflow_o=0.
//  - Reset wins over every other input.
//  All outputs are registered. The state after edge N reflects the inputs sampled at edge N: one-cycle latency.
//  States (implicit in count): EMPTY (cnt=0), PARTIAL (0<cnt<MAP_LEN), FULL (cnt=MAP_LEN).
//  Update rules, evaluated in this priority each edge:
//  - flush_i & wr: map <= {0.., ~branch_taken_i}, cnt <= 1.
//    The current branch is NOT part of the flushed packet.
//  - flush_i & !wr: map <= 0, cnt <= 0.
//  - !flush_i & wr & cnt<MAP_LEN: map[cnt] <= ~branch_taken_i, cnt <= cnt+1.
//    Other bits are unchanged.
//  - !flush_i & wr & cnt==MAP_LEN: map and cnt are unchanged; overflow_o <= 1.
//    This is a protocol error; the downstream stage must flush on full.
//  - otherwise: hold.
//  Bits at index >= cnt are always 0. Flush clears them; they are never written before cnt reaches them.
//  is_empty_o and is_full_o are registered copies derived from the next-state cnt.
//  - They never disagree with branches_o in the same cycle.
//  overflow_o clears only on reset.
//  flush_i while EMPTY is legal: no effect other than loading a concurrent wr.
//  Count arithmetic is unsigned CW-bit and never wraps: saturates at MAP_LEN per the rules above.
//  - No underflow path exists.
// TESTING
//  1 Reset: assert rst_i 2 cycles with wr=1 each cycle.
//    -> map_o=0, branches_o=0, is_empty_o=1, overflow_o=0.
//  2 Fill: 3 branches taken,not,taken (valid=qual=1).
//    -> after 3rd edge branches_o=3, map_o[2:0]=3'b010, is_empty_o=0.
//  3 Full: 31 not-taken branches.
//    -> map_o=31'h7FFFFFFF, branches_o=31, is_full_o=1.
//    One more branch with flush_i=0 -> map/count unchanged, overflow_o=1 and stays 1.
//  4 Flush+branch same cycle at cnt=31, taken.
//    -> branches_o=1, map_o=0, is_full_o=0, is_empty_o=0.
//    Flush alone next cycle -> branches_o=0, is_empty_o=1.
//  5 Filtering: is_branch_i=1 with qualified_i=0, then with valid_i=0.
//    -> no change to map_o/branches_o.
//  6 Reset mid-fill at cnt=10 with concurrent wr and flush.
//    -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/trdb_branch_map.sv
// trdb_branch_map: accumulates qualified branch outcomes (1 = not taken) into a map with count, empty/full and sticky overflow
module trdb_branch_map #(
  parameter int MAP_LEN = 31,
  localparam int CW = $clog2(MAP_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               qualified_i,
  input  logic               is_branch_i,
  input  logic               branch_taken_i,
  input  logic               flush_i,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CW-1:0]      branches_o,
  output logic               is_empty_o,
  output logic               is_full_o,
  output logic               overflow_o
);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAP_LEN);
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic act, wr;
  always_comb begin
    act = valid_i & qualified_i;
    wr = act & is_branch_i;
    map_d = map_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (act && flush_i) begin
      map_d = '0;
      map_d[0] = wr & ~branch_taken_i;
      cnt_d = {{(CW-1){1'b0}}, wr};
    end else if (wr && cnt_q < FULL_CNT) begin
      map_d[cnt_q] = ~branch_taken_i;
      cnt_d = cnt_q + 1'b1;
    end else if (wr) begin
      ovf_d = 1'b1;
    end
    empty_d = cnt_d == '0;
    full_d = cnt_d == FULL_CNT;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q <= '0;
      cnt_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      empty_q <= empty_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
    end
  end
  assign map_o = map_q;
  assign branches_o = cnt_q;
  assign is_empty_o = empty_q;
  assign is_full_o = full_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_trdb_branch_map.sv
// tb_trdb_branch_map: directed self-checking bench for trdb_branch_map
module tb_trdb_branch_map;
  logic clk = 1'b0;
  logic rst, valid, qual, isb, tkn, flush;
  logic [30:0] map;
  logic [4:0] br;
  logic empty, full, ovf;
  int checks = 0;
  int errors = 0;
  trdb_branch_map dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .qualified_i(qual), .is_branch_i(isb),
    .branch_taken_i(tkn), .flush_i(flush), .map_o(map), .branches_o(br),
    .is_empty_o(empty), .is_full_o(full), .overflow_o(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic q, input logic b, input logic t, input logic f);
    rst = r; valid = v; qual = q; isb = b; tkn = t; flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [30:0] m, input logic [4:0] c, input logic e, input logic fu, input logic o);
    chk({tag, ".map"}, 32'(map), 32'(m));
    chk({tag, ".cnt"}, 32'(br), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(fu));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask
  initial begin
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    chk_all("reset", 31'h0, 5'd0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk_all("fill1", 31'h0, 5'd1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk_all("fill3", 31'h2, 5'd3, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    chk_all("flush_only", 31'h0, 5'd0, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 1, 1, 0, 0);
    chk_all("fill30", 31'h3FFFFFFF, 5'd30, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    chk_all("full", 31'h7FFFFFFF, 5'd31, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    chk_all("overflow", 31'h7FFFFFFF, 5'd31, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0);
    chk_all("ovf_sticky", 31'h7FFFFFFF, 5'd31, 0, 1, 1);
    step(0, 1, 1, 1, 1, 1);
    chk_all("flush_wr_taken", 31'h0, 5'd1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    chk_all("flush_alone", 31'h0, 5'd0, 1, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    chk_all("flush_empty", 31'h0, 5'd0, 1, 0, 1);
    step(0, 1, 1, 1, 0, 1);
    chk_all("flush_wr_nt", 31'h1, 5'd1, 0, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    chk_all("unqualified", 31'h1, 5'd1, 0, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    chk_all("invalid", 31'h1, 5'd1, 0, 0, 1);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0, 0);
    chk_all("append", 31'h5, 5'd3, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1, i[0], 0);
    chk_all("fill10", 31'h155, 5'd10, 0, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    chk_all("reset_mid", 31'h0, 5'd0, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
